win_readout: RTL and testbench

//  Read-back side of the capture window. After the window writer has filled the

---
 rtl/win_pkg.sv | 16 +
 rtl/win_readout.sv | 102 ++++++++++
 tb/tb_win_readout.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/win_pkg.sv
// Shared types and default widths for the capture-window writer and readout.
package win_pkg;

  localparam int WIN_CNT_W  = 18;
  localparam int WIN_ADDR_W = 18;
  localparam int WIN_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/win_readout.sv
// Streams WIN_DATA+1 words from the circular sample RAM to the MCU via valid/ack.
// Optional WIN_READOUT_PRETRIG_EN adds a PRETRIG offset subtracted from trig_addr.
//
// state | meaning
// IDLE  | waiting for Start_Read with Write_Ready
// FETCH | RAM read strobe issued for current address
// LATCH | RAM data captured into rd_data
// HOLD  | rd_valid high, waiting for rd_ack
// DONE  | all words transferred, Read_Done high
module win_readout
  import win_pkg::*;
#(
  parameter int ADDR_W = WIN_ADDR_W,
  parameter int DATA_W = WIN_DATA_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Start_Read,
  input  logic                 Write_Ready,
  input  logic [WIN_CNT_W-1:0] WIN_DATA,
  input  logic [ADDR_W-1:0]    trig_addr,
`ifdef WIN_READOUT_PRETRIG_EN
  input  logic [ADDR_W-1:0]    PRETRIG,
`endif
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_data,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ack,
  output logic                 Read_Done
);

  state_t               state;
  logic [WIN_CNT_W-1:0] cnt;
  logic [WIN_CNT_W-1:0] win_len;
  logic [ADDR_W-1:0]    start_addr;

  // Subtraction wraps naturally at ADDR_W bits, matching the circular RAM.
`ifdef WIN_READOUT_PRETRIG_EN
  always_comb start_addr = trig_addr - PRETRIG;
`else
  always_comb start_addr = trig_addr;
`endif

  // mem_addr doubles as the running read address.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      Read_Done <= 1'b0;
      cnt       <= '0;
      win_len   <= '0;
    end else if (!Start_Read) begin
      state     <= IDLE;
      mem_rd_en <= 1'b0;
      rd_valid  <= 1'b0;
      Read_Done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Write_Ready) begin
            mem_addr  <= start_addr;
            cnt       <= '0;
            win_len   <= WIN_DATA;
            mem_rd_en <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          mem_rd_en <= 1'b0;
          state     <= LATCH;
        end
        LATCH: begin
          rd_data  <= mem_data;
          rd_valid <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (rd_ack) begin
            rd_valid <= 1'b0;
            if (cnt == win_len) begin
              Read_Done <= 1'b1;
              state     <= DONE;
            end else begin
              cnt       <= cnt + 1'b1;
              mem_addr  <= mem_addr + 1'b1;
              mem_rd_en <= 1'b1;
              state     <= FETCH;
            end
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_win_readout.sv
// Scoreboard bench for win_readout: a driver queues expected fetch addresses and
// words from a reference model; a negedge monitor pops and compares them.
module tb_win_readout;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start_Read;
  logic        Write_Ready;
  logic [17:0] WIN_DATA;
  logic [17:0] trig_addr;
`ifdef WIN_READOUT_PRETRIG_EN
  logic [17:0] PRETRIG;
`endif
  logic        mem_rd_en;
  logic [17:0] mem_addr;
  logic [15:0] mem_data;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ack;
  logic        Read_Done;

  int n_pass = 0;
  int n_total = 0;

  logic [17:0] exp_addr_q[$];
  logic [15:0] exp_word_q[$];

  always #5 CLK = ~CLK;

  win_readout dut (
    .CLK(CLK), .RST(RST), .Start_Read(Start_Read), .Write_Ready(Write_Ready),
    .WIN_DATA(WIN_DATA), .trig_addr(trig_addr),
`ifdef WIN_READOUT_PRETRIG_EN
    .PRETRIG(PRETRIG),
`endif
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ack(rd_ack), .Read_Done(Read_Done)
  );

  function automatic logic [15:0] ram_word(input logic [17:0] a);
    logic [31:0] t;
    t = {14'd0, a} * 32'd40503 + 32'h1234;
    return t[15:0] ^ {14'd0, a[17:16]};
  endfunction

  // RAM: data valid only the cycle after a read strobe
  always @(posedge CLK) mem_data <= mem_rd_en ? ram_word(mem_addr) : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (mem_rd_en) begin
        if (exp_addr_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_fetch: got addr 0x%0h expected no fetch", mem_addr);
        end else chk("fetch_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
      end
      if (rd_valid && rd_ack && Start_Read) begin
        if (exp_word_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_word: got 0x%0h expected no transfer", rd_data);
        end else chk("word_data", 32'(rd_data), 32'(exp_word_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input logic [17:0] trig, input int win, input logic [17:0] pre,
                     input int max_dly, input int abort_at, input bit stray, input int slow_idx);
    int last;
    int lat;
    int dly;
    logic [17:0] a;
    logic [15:0] held;
    last = (abort_at >= 0) ? abort_at : win;
    for (int i = 0; i <= last; i++) begin
      a = 18'({14'd0, trig} - {14'd0, pre} + 32'(i));
      exp_addr_q.push_back(a);
      if (i != abort_at) exp_word_q.push_back(ram_word(a));
    end
    WIN_DATA   = 18'(win);
    trig_addr  = trig;
`ifdef WIN_READOUT_PRETRIG_EN
    PRETRIG    = pre;
`endif
    Start_Read = 1'b1;
    Write_Ready = 1'b1;
    step();
    WIN_DATA  = 18'($urandom);
    trig_addr = 18'($urandom);
`ifdef WIN_READOUT_PRETRIG_EN
    PRETRIG   = 18'($urandom);
`endif
    lat = 1;
    for (int i = 0; i <= last; i++) begin
      while (!rd_valid && lat < 20) begin
        step();
        lat++;
      end
      chk("word_latency", 32'(lat), 32'd3);
      if (!rd_valid) begin
        Start_Read = 1'b0;
        step();
        exp_addr_q.delete();
        exp_word_q.delete();
        return;
      end
      held = rd_data;
      dly = (i == slow_idx) ? 5 : int'($urandom_range(max_dly, 0));
      repeat (dly) begin
        step();
        chk("hold_valid", 32'(rd_valid), 32'd1);
        chk("hold_data", 32'(rd_data), 32'(held));
      end
      if (i == abort_at) begin
        Start_Read = 1'b0;
        step();
        chk("abort_valid", 32'(rd_valid), 32'd0);
        chk("abort_rd_en", 32'(mem_rd_en), 32'd0);
        chk("abort_done", 32'(Read_Done), 32'd0);
        chk("abort_keeps_data", 32'(rd_data), 32'(held));
        step();
        chk("abort_queue", 32'(exp_addr_q.size()), 32'd0);
        return;
      end
      rd_ack = 1'b1;
      step();
      lat = 1;
      if (stray && i < last) begin
        step();
        lat = 2;
      end
      rd_ack = 1'b0;
    end
    chk("read_done", 32'(Read_Done), 32'd1);
    step();
    chk("done_held", 32'(Read_Done), 32'd1);
    chk("done_no_valid", 32'(rd_valid), 32'd0);
    Start_Read = 1'b0;
    step();
    chk("done_clear", 32'(Read_Done), 32'd0);
    chk("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    chk("word_queue_empty", 32'(exp_word_q.size()), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int win;
    int ab;
    logic [17:0] pre;
    RST = 1'b1; Start_Read = 1'b0; Write_Ready = 1'b0; rd_ack = 1'b0;
    WIN_DATA = '0; trig_addr = '0;
`ifdef WIN_READOUT_PRETRIG_EN
    PRETRIG = '0;
`endif
    step(); step();
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_done", 32'(Read_Done), 32'd0);
    RST = 1'b0;

    // reset while holding a word
    exp_addr_q.push_back(18'h55);
    WIN_DATA = 18'd3; trig_addr = 18'h55; Start_Read = 1'b1; Write_Ready = 1'b1;
    for (int k = 0; k < 20 && !rd_valid; k++) step();
    chk("pre_reset_valid", 32'(rd_valid), 32'd1);
    RST = 1'b1;
    step(); step();
    chk("midrst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    chk("midrst_data", 32'(rd_data), 32'd0);
    chk("midrst_valid", 32'(rd_valid), 32'd0);
    chk("midrst_done", 32'(Read_Done), 32'd0);
    exp_addr_q.delete();
    exp_word_q.delete();
    Write_Ready = 1'b0;
    RST = 1'b0;
    repeat (4) begin
      step();
      chk("no_fetch_without_ready", 32'(mem_rd_en), 32'd0);
    end
    Start_Read = 1'b0;
    step();

    run(18'h10, 3, 18'h0, 0, -1, 1'b0, -1);
    run(18'h3FFFE, 3, 18'h0, 0, -1, 1'b0, -1);
    run(18'h20, 4, 18'h0, 1, -1, 1'b1, 2);
    run(18'h30, 3, 18'h0, 0, 1, 1'b0, -1);
    run(18'h30, 3, 18'h0, 0, -1, 1'b0, -1);
    run(18'h40, 0, 18'h0, 2, -1, 1'b0, -1);
`ifdef WIN_READOUT_PRETRIG_EN
    run(18'h2, 0, 18'h4, 0, -1, 1'b0, -1);
`endif
    for (int r = 0; r < 12; r++) begin
      win = int'($urandom_range(6, 0));
      ab = ($urandom_range(4, 0) == 0) ? int'($urandom_range(win, 0)) : -1;
`ifdef WIN_READOUT_PRETRIG_EN
      pre = 18'($urandom);
`else
      pre = 18'h0;
`endif
      run(18'($urandom), win, pre, 3, ab, 1'($urandom), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
